// File: rtl/ux607_sram_burst_splitter.sv
// ux607_sram_burst_splitter
//   Front-end for the single-cycle SRAM controller. Accepts one burst command
//   at a time, issues one uop per beat to the controller and folds the per-beat
//   responses back into burst responses: one response per beat for reads
//   (last flagged), a single response per burst for writes.
//
// Configuration macro:
//   UX607_SRAM_BURST_WRAP_EN  - enables wrapping bursts (bst_cmd_wrap). When
//                               undefined bst_cmd_wrap is ignored.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   bst_cmd_*            burst command (read, addr, len = beats-1, wrap, usr)
//   bst_wdat_*           write beats, passed through to uop_cmd_wdata/wmask
//   bst_rsp_*            burst responses (rdata, err, last, usr)
//   uop_cmd_*            per-beat command to the SRAM controller
//   uop_rsp_*            per-beat response from the SRAM controller
//   splitter_active      high whenever a burst is in progress
module ux607_sram_burst_splitter #(
    parameter int unsigned DW     = 64,
    parameter int unsigned MW     = 8,
    parameter int unsigned AW     = 32,
    parameter int unsigned AW_LSB = 3,
    parameter int unsigned USR_W  = 3,
    parameter int unsigned LENW   = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              bst_cmd_valid,
    output logic              bst_cmd_ready,
    input  logic              bst_cmd_read,
    input  logic [AW-1:0]     bst_cmd_addr,
    input  logic [LENW-1:0]   bst_cmd_len,
    input  logic              bst_cmd_wrap,
    input  logic [USR_W-1:0]  bst_cmd_usr,

    input  logic              bst_wdat_valid,
    output logic              bst_wdat_ready,
    input  logic [DW-1:0]     bst_wdat_data,
    input  logic [MW-1:0]     bst_wdat_mask,

    output logic              bst_rsp_valid,
    input  logic              bst_rsp_ready,
    output logic [DW-1:0]     bst_rsp_rdata,
    output logic              bst_rsp_err,
    output logic              bst_rsp_last,
    output logic [USR_W-1:0]  bst_rsp_usr,

    output logic              uop_cmd_valid,
    input  logic              uop_cmd_ready,
    output logic              uop_cmd_read,
    output logic [AW-1:0]     uop_cmd_addr,
    output logic [DW-1:0]     uop_cmd_wdata,
    output logic [MW-1:0]     uop_cmd_wmask,
    output logic [1:0]        uop_cmd_size,
    output logic [USR_W-1:0]  uop_cmd_usr,

    input  logic              uop_rsp_valid,
    output logic              uop_rsp_ready,
    input  logic              uop_rsp_err,
    input  logic [DW-1:0]     uop_rsp_rdata,
    input  logic [USR_W-1:0]  uop_rsp_usr,

    output logic              splitter_active
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_WR    = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [AW-1:0] ALIGN_MASK = {{(AW-AW_LSB){1'b1}}, {AW_LSB{1'b0}}};
    localparam logic [AW-1:0] BEAT_STEP  = AW'(1) << AW_LSB;

    state_e            state_q, state_d;
    logic              read_q,  read_d;
    logic [AW-1:0]     addr_q,  addr_d;
    logic [LENW-1:0]   len_q,   len_d;
    logic [LENW-1:0]   icnt_q,  icnt_d;
    logic [LENW-1:0]   rcnt_q,  rcnt_d;
    logic [USR_W-1:0]  usr_q,   usr_d;
    logic              err_q,   err_d;
    logic              wrap_q,  wrap_d;

    logic              wrap_ok;
    logic [AW-1:0]     step_addr;
    logic [AW-1:0]     next_addr;
    logic              last_rsp;
    logic              cmd_fire;
    logic              rsp_fire;

    assign step_addr = addr_q + BEAT_STEP;

`ifdef UX607_SRAM_BURST_WRAP_EN
    logic [AW-1:0] wrap_mask;

    // A wrap window only exists for power-of-two beat counts above one.
    assign wrap_ok = bst_cmd_wrap && (bst_cmd_len != '0) &&
                     ((bst_cmd_len & (bst_cmd_len + 1'b1)) == '0);

    // len is 2^k-1, so {len, all-ones} selects exactly the bits that advance.
    assign wrap_mask = AW'({len_q, {AW_LSB{1'b1}}});
    assign next_addr = wrap_q ? ((addr_q & ~wrap_mask) | (step_addr & wrap_mask))
                              : step_addr;
`else
    logic unused_wrap;

    assign wrap_ok     = 1'b0;
    assign unused_wrap = bst_cmd_wrap | wrap_q;
    assign next_addr   = step_addr;
`endif

    assign last_rsp        = (rcnt_q == len_q);
    assign uop_cmd_addr    = addr_q;
    assign uop_cmd_usr     = usr_q;
    assign uop_cmd_size    = AW_LSB[1:0];
    assign splitter_active = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            read_q  <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            icnt_q  <= '0;
            rcnt_q  <= '0;
            usr_q   <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            icnt_q  <= icnt_d;
            rcnt_q  <= rcnt_d;
            usr_q   <= usr_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        read_d         = read_q;
        addr_d         = addr_q;
        len_d          = len_q;
        icnt_d         = icnt_q;
        rcnt_d         = rcnt_q;
        usr_d          = usr_q;
        err_d          = err_q;
        wrap_d         = wrap_q;

        bst_cmd_ready  = 1'b0;
        bst_wdat_ready = 1'b0;
        uop_cmd_valid  = 1'b0;
        uop_cmd_read   = 1'b0;
        uop_cmd_wdata  = '0;
        uop_cmd_wmask  = '0;
        bst_rsp_valid  = 1'b0;
        bst_rsp_rdata  = '0;
        bst_rsp_err    = 1'b0;
        bst_rsp_last   = 1'b0;
        bst_rsp_usr    = '0;
        uop_rsp_ready  = 1'b0;
        cmd_fire       = 1'b0;
        rsp_fire       = 1'b0;

        // Every handshake is masked while rst is high so nothing issues or
        // retires in the reset cycle itself.
        if (!rst) begin
            // Command side
            unique case (state_q)
                S_IDLE: begin
                    bst_cmd_ready = 1'b1;
                    if (bst_cmd_valid) begin
                        read_d  = bst_cmd_read;
                        addr_d  = bst_cmd_addr & ALIGN_MASK;
                        len_d   = bst_cmd_len;
                        usr_d   = bst_cmd_usr;
                        wrap_d  = wrap_ok;
                        icnt_d  = '0;
                        rcnt_d  = '0;
                        err_d   = 1'b0;
                        state_d = bst_cmd_read ? S_RD : S_WR;
                    end
                end
                S_RD: begin
                    uop_cmd_valid = 1'b1;
                    uop_cmd_read  = 1'b1;
                end
                S_WR: begin
                    uop_cmd_valid  = bst_wdat_valid;
                    bst_wdat_ready = uop_cmd_ready;
                    uop_cmd_wdata  = bst_wdat_data;
                    uop_cmd_wmask  = bst_wdat_mask;
                end
                default: ;
            endcase

            cmd_fire = uop_cmd_valid && uop_cmd_ready;
            if (cmd_fire) begin
                icnt_d = icnt_q + 1'b1;
                addr_d = next_addr;
                if (icnt_q == len_q) begin
                    state_d = S_DRAIN;
                end
            end

            // Response side: beats may return while commands are still issuing.
            if (state_q != S_IDLE) begin
                if (read_q) begin
                    bst_rsp_valid = uop_rsp_valid;
                    uop_rsp_ready = bst_rsp_ready;
                    bst_rsp_rdata = uop_rsp_rdata;
                    bst_rsp_err   = uop_rsp_err;
                    bst_rsp_usr   = uop_rsp_usr;
                    bst_rsp_last  = last_rsp;
                end else if (!last_rsp) begin
                    // Intermediate write beats are absorbed into the sticky error.
                    uop_rsp_ready = 1'b1;
                end else begin
                    bst_rsp_valid = uop_rsp_valid;
                    uop_rsp_ready = bst_rsp_ready;
                    bst_rsp_err   = err_q | uop_rsp_err;
                    bst_rsp_usr   = usr_q;
                    bst_rsp_last  = 1'b1;
                end

                rsp_fire = uop_rsp_valid && uop_rsp_ready;
                if (rsp_fire) begin
                    rcnt_d = rcnt_q + 1'b1;
                    if (!read_q) begin
                        err_d = err_q | uop_rsp_err;
                    end
                    // Also covers a final beat retiring in the same cycle as
                    // the last command issue.
                    if (last_rsp) begin
                        state_d = S_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ux607_sram_burst_splitter.sv
// Testbench for ux607_sram_burst_splitter. The SRAM controller is modelled as
// a response queue with a one-cycle minimum latency; expected addresses and
// responses are computed per burst from the burst rules with plain arithmetic.
module tb_ux607_sram_burst_splitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        bst_cmd_valid, bst_cmd_ready, bst_cmd_read, bst_cmd_wrap;
    logic [31:0] bst_cmd_addr;
    logic [3:0]  bst_cmd_len;
    logic [2:0]  bst_cmd_usr;
    logic        bst_wdat_valid, bst_wdat_ready;
    logic [63:0] bst_wdat_data;
    logic [7:0]  bst_wdat_mask;
    logic        bst_rsp_valid, bst_rsp_ready, bst_rsp_err, bst_rsp_last;
    logic [63:0] bst_rsp_rdata;
    logic [2:0]  bst_rsp_usr;
    logic        uop_cmd_valid, uop_cmd_ready, uop_cmd_read;
    logic [31:0] uop_cmd_addr;
    logic [63:0] uop_cmd_wdata;
    logic [7:0]  uop_cmd_wmask;
    logic [1:0]  uop_cmd_size;
    logic [2:0]  uop_cmd_usr;
    logic        uop_rsp_valid, uop_rsp_ready, uop_rsp_err;
    logic [63:0] uop_rsp_rdata;
    logic [2:0]  uop_rsp_usr;
    logic        splitter_active;

    ux607_sram_burst_splitter #(
        .DW(64), .MW(8), .AW(32), .AW_LSB(3), .USR_W(3), .LENW(4)
    ) dut (
        .clk(clk), .rst(rst),
        .bst_cmd_valid(bst_cmd_valid), .bst_cmd_ready(bst_cmd_ready),
        .bst_cmd_read(bst_cmd_read), .bst_cmd_addr(bst_cmd_addr),
        .bst_cmd_len(bst_cmd_len), .bst_cmd_wrap(bst_cmd_wrap), .bst_cmd_usr(bst_cmd_usr),
        .bst_wdat_valid(bst_wdat_valid), .bst_wdat_ready(bst_wdat_ready),
        .bst_wdat_data(bst_wdat_data), .bst_wdat_mask(bst_wdat_mask),
        .bst_rsp_valid(bst_rsp_valid), .bst_rsp_ready(bst_rsp_ready),
        .bst_rsp_rdata(bst_rsp_rdata), .bst_rsp_err(bst_rsp_err),
        .bst_rsp_last(bst_rsp_last), .bst_rsp_usr(bst_rsp_usr),
        .uop_cmd_valid(uop_cmd_valid), .uop_cmd_ready(uop_cmd_ready),
        .uop_cmd_read(uop_cmd_read), .uop_cmd_addr(uop_cmd_addr),
        .uop_cmd_wdata(uop_cmd_wdata), .uop_cmd_wmask(uop_cmd_wmask),
        .uop_cmd_size(uop_cmd_size), .uop_cmd_usr(uop_cmd_usr),
        .uop_rsp_valid(uop_rsp_valid), .uop_rsp_ready(uop_rsp_ready),
        .uop_rsp_err(uop_rsp_err), .uop_rsp_rdata(uop_rsp_rdata),
        .uop_rsp_usr(uop_rsp_usr),
        .splitter_active(splitter_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
        logic        last;
        logic [2:0]  usr;
    } rsp_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
        logic [2:0]  usr;
    } crsp_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          cyc      = 0;

    bit          active, accepted, b_read, timing_chk;
    int          b_len, icnt_m, wcnt_m, rsp_seen, acc_cyc;
    logic [2:0]  b_usr;
    logic [31:0] exp_addr [16];
    logic [63:0] exp_wd   [16];
    logic [7:0]  exp_wm   [16];
    bit          errv     [16];
    rsp_t        exp_q [$];
    crsp_t       cq    [$];
    int          rdy_mode, rsp_mode, wd_mode, stall_lo;
    bit          pop_cq, cmd_acc_now, wd_fire;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rd_data(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a};
    endfunction

    // Beat address from the burst rules: incrementing modulo 2^32, or cycling
    // through an aligned window of (len+1)*8 bytes for eligible wrap bursts.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input int len,
                                               input bit wrap, input int i);
        longint unsigned base, win, wstart;
        bit ok, w;
        base = longint'(a) & 64'hFFFF_FFF8;
        ok   = wrap && (len == 1 || len == 3 || len == 7 || len == 15);
`ifdef UX607_SRAM_BURST_WRAP_EN
        w = ok;
`else
        w = ok && 1'b0;
`endif
        if (w) begin
            win    = longint'(len + 1) * 8;
            wstart = base - (base % win);
            return 32'(wstart + ((base - wstart + longint'(i) * 8) % win));
        end
        return 32'(base + longint'(i) * 8);
    endfunction

    task automatic observe();
        rsp_t e;
        pop_cq      = uop_rsp_valid && uop_rsp_ready;
        cmd_acc_now = bst_cmd_valid && bst_cmd_ready;
        wd_fire     = bst_wdat_valid && bst_wdat_ready;
        if (!active) return;
        if (cmd_acc_now) acc_cyc = cyc + 1;
        if (accepted) begin
            check_eq("cmd_rdy_busy", bst_cmd_ready, 0);
            check_eq("active_busy", splitter_active, 1);
            if (b_read) begin
                check_eq("uop_vld_rd", uop_cmd_valid, icnt_m <= b_len);
            end else begin
                check_eq("uop_vld_wr", uop_cmd_valid, bst_wdat_valid && icnt_m <= b_len);
                check_eq("wdat_rdy", bst_wdat_ready, uop_cmd_ready && icnt_m <= b_len);
            end
        end
        if (uop_cmd_valid && uop_cmd_ready) begin
            if (!accepted || icnt_m > b_len) begin
                check_eq("extra_uop", uop_cmd_valid, 0);
            end else begin
                check_eq("uop_addr", uop_cmd_addr, exp_addr[icnt_m]);
                check_eq("uop_read", uop_cmd_read, b_read);
                check_eq("uop_usr", uop_cmd_usr, b_usr);
                check_eq("uop_size", uop_cmd_size, 2'd3);
                if (!b_read) begin
                    check_eq("uop_wdata", uop_cmd_wdata, exp_wd[icnt_m]);
                    check_eq("uop_wmask", uop_cmd_wmask, exp_wm[icnt_m]);
                end
                if (timing_chk) check_eq("uop_cyc", cyc + 1, acc_cyc + 1 + icnt_m);
                cq.push_back('{rd_data(uop_cmd_addr), errv[icnt_m], uop_cmd_usr});
                icnt_m++;
            end
        end
        if (bst_rsp_valid && bst_rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_rsp", bst_rsp_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("rsp_rdata", bst_rsp_rdata, e.rdata);
                check_eq("rsp_err", bst_rsp_err, e.err);
                check_eq("rsp_last", bst_rsp_last, e.last);
                check_eq("rsp_usr", bst_rsp_usr, e.usr);
                if (timing_chk) check_eq("rsp_cyc", cyc + 1, acc_cyc + 2 + rsp_seen);
                rsp_seen++;
            end
        end
    endtask

    task automatic drive();
        if (pop_cq && cq.size() > 0) void'(cq.pop_front());
        if (cmd_acc_now) begin
            accepted      = 1'b1;
            bst_cmd_valid = 1'b0;
            stall_lo      = cyc + 3;
        end
        if (wd_fire) wcnt_m++;
        uop_rsp_valid = (cq.size() > 0);
        if (cq.size() > 0) begin
            uop_rsp_rdata = cq[0].rdata;
            uop_rsp_err   = cq[0].err;
            uop_rsp_usr   = cq[0].usr;
        end else begin
            uop_rsp_rdata = '0;
            uop_rsp_err   = 1'b0;
            uop_rsp_usr   = '0;
        end
        uop_cmd_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        case (rsp_mode)
            0:       bst_rsp_ready = 1'b1;
            1:       bst_rsp_ready = ($urandom_range(0, 2) != 0);
            default: bst_rsp_ready = !(cyc >= stall_lo && cyc < stall_lo + 3);
        endcase
        if (active && accepted && !b_read && wcnt_m <= b_len) begin
            case (wd_mode)
                0:       bst_wdat_valid = 1'b1;
                1:       bst_wdat_valid = ((cyc % 2) == 0);
                default: bst_wdat_valid = ($urandom_range(0, 1) != 0);
            endcase
            bst_wdat_data = exp_wd[wcnt_m];
            bst_wdat_mask = exp_wm[wcnt_m];
        end else begin
            bst_wdat_valid = 1'b0;
            bst_wdat_data  = '0;
            bst_wdat_mask  = '0;
        end
    endtask

    task automatic finish_edge();
        observe();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic step();
        @(negedge clk);
        finish_edge();
    endtask

    task automatic start_burst(input bit rd, input logic [31:0] a, input int len,
                               input bit wrap, input logic [2:0] usr, input int rdym,
                               input int rspm, input int wdm, input bit tchk);
        bit werr;
        werr = 1'b0;
        exp_q.delete();
        for (int i = 0; i <= len; i++) begin
            exp_addr[i] = model_addr(a, len, wrap, i);
            exp_wd[i]   = {$urandom, $urandom};
            exp_wm[i]   = 8'($urandom);
            werr        = werr | errv[i];
            if (rd) exp_q.push_back('{rd_data(exp_addr[i]), errv[i], (i == len), usr});
        end
        if (!rd) exp_q.push_back('{64'h0, werr, 1'b1, usr});
        b_read = rd; b_len = len; b_usr = usr;
        rdy_mode = rdym; rsp_mode = rspm; wd_mode = wdm; timing_chk = tchk;
        icnt_m = 0; wcnt_m = 0; rsp_seen = 0; accepted = 1'b0; active = 1'b1;
        stall_lo = 1 << 30;
        bst_cmd_valid = 1'b1;
        bst_cmd_read  = rd;
        bst_cmd_addr  = a;
        bst_cmd_len   = 4'(len);
        bst_cmd_wrap  = wrap;
        bst_cmd_usr   = usr;
    endtask

    task automatic run_burst(input bit rd, input logic [31:0] a, input int len,
                             input bit wrap, input logic [2:0] usr, input int rdym,
                             input int rspm, input int wdm, input bit tchk);
        int budget;
        start_burst(rd, a, len, wrap, usr, rdym, rspm, wdm, tchk);
        budget = 0;
        while ((!accepted || exp_q.size() > 0) && budget < 1000) begin
            step();
            budget++;
        end
        check_eq("burst_timeout", 64'(exp_q.size()), 0);
        check_eq("beats_issued", icnt_m, len + 1);
        active = 1'b0;
        bst_cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("cmd_rdy_after", bst_cmd_ready, 1);
        check_eq("idle_after", splitter_active, 0);
        finish_edge();
        for (int i = 0; i < 16; i++) errv[i] = 1'b0;
    endtask

    task automatic reset_test();
        int budget;
        start_burst(1'b1, 32'h200, 7, 1'b0, 3'd5, 0, 0, 0, 1'b0);
        budget = 0;
        while (icnt_m < 2 && budget < 50) begin
            step();
            budget++;
        end
        check_eq("rst_pre_issue", icnt_m, 2);
        rst = 1'b1;
        active = 1'b0;
        exp_q.delete();
        cq.delete();
        uop_rsp_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_uop_gated", uop_cmd_valid, 0);
        check_eq("rst_cmd_rdy", bst_cmd_ready, 0);
        observe();
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        drive();
        @(negedge clk);
        check_eq("rst_idle", splitter_active, 0);
        check_eq("rst_cmd_rdy_after", bst_cmd_ready, 1);
        for (int i = 0; i < 6; i++) begin
            check_eq("rst_no_uop", uop_cmd_valid, 0);
            check_eq("rst_no_rsp", bst_rsp_valid, 0);
            finish_edge();
            @(negedge clk);
        end
        finish_edge();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bst_cmd_valid = 1'b0; bst_cmd_read = 1'b0; bst_cmd_addr = '0;
        bst_cmd_len = '0; bst_cmd_wrap = 1'b0; bst_cmd_usr = '0;
        bst_wdat_valid = 1'b0; bst_wdat_data = '0; bst_wdat_mask = '0;
        bst_rsp_ready = 1'b0; uop_cmd_ready = 1'b0;
        uop_rsp_valid = 1'b0; uop_rsp_err = 1'b0; uop_rsp_rdata = '0; uop_rsp_usr = '0;
        active = 1'b0; accepted = 1'b0;
        rdy_mode = 0; rsp_mode = 0; wd_mode = 0; stall_lo = 1 << 30;
        pop_cq = 1'b0; cmd_acc_now = 1'b0; wd_fire = 1'b0;
        for (int i = 0; i < 16; i++) errv[i] = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_cmd_ready", bst_cmd_ready, 0);
            check_eq("rst_uop_valid", uop_cmd_valid, 0);
            check_eq("rst_wdat_ready", bst_wdat_ready, 0);
            check_eq("rst_rsp_valid", bst_rsp_valid, 0);
            check_eq("rst_uop_rsp_ready", uop_rsp_ready, 0);
            check_eq("rst_active", splitter_active, 0);
        end
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        drive();
        @(negedge clk);
        check_eq("cmd_ready_release", bst_cmd_ready, 1);
        finish_edge();

        // 4-beat read, controller always ready, latency checked
        run_burst(1'b1, 32'h100, 3, 1'b0, 3'd1, 0, 0, 0, 1'b1);
        // 3-beat write with wdat valid every other cycle
        run_burst(1'b0, 32'h40, 2, 1'b0, 3'd2, 0, 0, 1, 1'b0);
        // same write, error on beat 1 only
        errv[1] = 1'b1;
        run_burst(1'b0, 32'h40, 2, 1'b0, 3'd3, 0, 0, 1, 1'b0);
        // 4-beat wrap read at 0x118
        run_burst(1'b1, 32'h118, 3, 1'b1, 3'd4, 0, 0, 0, 1'b1);
        // 8-beat read with response back-pressure for 3 cycles
        run_burst(1'b1, 32'h300, 7, 1'b0, 3'd6, 0, 2, 0, 1'b0);
        // top of address space, unaligned start
        run_burst(1'b1, 32'hFFFF_FFF3, 3, 1'b0, 3'd7, 0, 0, 0, 1'b1);
        // 16-beat wrap write
        run_burst(1'b0, 32'h1238, 15, 1'b1, 3'd0, 0, 0, 0, 1'b0);
        // reset mid-burst
        reset_test();

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                            : $urandom;
            for (int i = 0; i < 16; i++) errv[i] = ($urandom_range(0, 5) == 0);
            run_burst(1'($urandom_range(0, 1)), a, $urandom_range(0, 15),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ux607_sram_burst_splitter.md
# ux607_sram_burst_splitter

Upstream front-end for the single-cycle SRAM controller. Accepts one burst command at a time (incrementing, or optionally wrapping), and splits it into per-beat uop commands on the controller's `uop_cmd_*` port. It reassembles the controller's `uop_rsp_*` beats into burst responses:
- reads: one response per beat, with `last` flagged;
- writes: one response per burst.

## Interface
- `DW`, 64: data width per beat.
- `MW`, 8: write mask width (DW/8).
- `AW`, 32: byte address width.
- `AW_LSB`, 3: log2 bytes per beat; address step is 2^AW_LSB.
- `USR_W`, 3: user tag width, carried unchanged.
- `LENW`, 4: burst length field width; beats = len+1, max 2^LENW.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `bst_cmd_valid` / `bst_cmd_ready`  in/out  1  burst command handshake.
- `bst_cmd_read`  in  1  1=read burst, 0=write burst.
- `bst_cmd_addr`  in  AW  start byte address; low AW_LSB bits ignored.
- `bst_cmd_len`  in  LENW  beats minus one.
- `bst_cmd_wrap`  in  1  wrapping burst request.
- `bst_cmd_usr`  in  USR_W  user tag.
- `bst_wdat_valid` / `bst_wdat_ready`  in/out  1  write-beat handshake.
- `bst_wdat_data`  in  DW  write data.
- `bst_wdat_mask`  in  MW  byte mask.
- `bst_rsp_valid` / `bst_rsp_ready`  out/in  1  burst response handshake.
- `bst_rsp_rdata`  out  DW  read data (0 on write responses).
- `bst_rsp_err`  out  1  error.
- `bst_rsp_last`  out  1  final response of the burst.
- `bst_rsp_usr`  out  USR_W  tag of the burst.
- `uop_cmd_valid` / `uop_cmd_ready`  out/in  1  per-beat command to the SRAM controller.
- `uop_cmd_read`  out  1  per-beat read/write.
- `uop_cmd_addr`  out  AW  per-beat address.
- `uop_cmd_wdata`  out  DW  per-beat write data.
- `uop_cmd_wmask`  out  MW  per-beat byte mask.
- `uop_cmd_size`  out  2  constant AW_LSB[1:0].
- `uop_cmd_usr`  out  USR_W  per-beat tag.
- `uop_rsp_valid` / `uop_rsp_ready`  in/out  1  per-beat response from the controller.
- `uop_rsp_err`  in  1  per-beat error.
- `uop_rsp_rdata`  in  DW  per-beat read data.
- `uop_rsp_usr`  in  USR_W  per-beat tag.
- `splitter_active`  out  1  high when state != IDLE.

## Operation
FSM states:
- IDLE: `bst_cmd_ready`=1. On accept, latch read, addr (aligned), len, wrap, usr, and clear issue count `icnt`, return count `rcnt` and sticky error. Go to RD or WR.
- RD:
  - `uop_cmd_valid`=1, `uop_cmd_read`=1.
  - Each `uop_cmd` handshake increments `icnt` and advances the address.
  - At the handshake with `icnt`==len, go to DRAIN.
- WR:
  - `uop_cmd_valid` = `bst_wdat_valid`.
  - `bst_wdat_ready` = `uop_cmd_ready`; data and mask pass through combinationally.
  - `uop_cmd_read`=0.
  - Counting and address advance are the same as RD; go to DRAIN after the last beat.
- DRAIN: stays until the response with `rcnt`==len completes its handshake on the `bst_rsp` side, then goes to IDLE.

Read responses:
- `bst_rsp_valid` = `uop_rsp_valid`; `uop_rsp_ready` = `bst_rsp_ready`.
- rdata, err and usr pass through.
- `bst_rsp_last` = (`rcnt`==len).

Write responses:
- Non-last beats: `uop_rsp_ready`=1, `bst_rsp_valid`=0. Each beat's err is ORed into the sticky error.
- Last beat: forwarded with err = sticky | `uop_rsp_err`, `last`=1, rdata=0.

Counters and address:
- `rcnt` increments on every `uop_rsp` handshake.
- Next address = addr + 2^AW_LSB, modulo 2^AW (wraps past top of address space silently).
- `bst_wdat_ready`=0 outside WR.
- `uop_cmd_valid`=0 in IDLE and DRAIN.

## Timing
- Reset values:
  - state IDLE; all counters 0; sticky error 0;
  - `bst_cmd_ready`=0 while `rst`=1, 1 from the first cycle after release;
  - all other valid/ready outputs 0; `splitter_active`=0.
- First `uop_cmd_valid` is asserted in the cycle after burst accept; command-to-uop latency is 1 cycle.
- With `uop_cmd_ready` held high, one beat issues per cycle. An N-beat read returns its last response 2+N-1 cycles after accept (includes the controller's 1-cycle pipe).
- `bst_cmd_ready` stays low from accept until the cycle after the final response handshake. There is no overlap of bursts.
- Stall rules:
  - `uop_cmd_ready`=0: hold address and beat count.
  - `bst_rsp_ready`=0: back-pressures the controller; no data is lost.
- A new burst cannot be accepted in the same cycle as a final response.
- `rst` asserted mid-burst: return to IDLE next cycle and issue no further uops. Beats already in the controller are dropped by the shared reset.

## Configuration
- `UX607_SRAM_BURST_WRAP_EN` defined:
  - When `bst_cmd_wrap`=1, the address wraps within an aligned window of (len+1)×2^AW_LSB bytes.
  - Only the low AW_LSB+log2(len+1) bits advance.
  - len must be 1, 3, 7 or 15. For any other len, `bst_cmd_wrap` is treated as 0.
- Macro not defined: `bst_cmd_wrap` is ignored, all bursts increment, and the wrap logic is absent.

## Test plan
- Reset, then a 4-beat read at 0x100 with the controller always ready → uop addrs 0x100, 0x108, 0x110, 0x118 on consecutive cycles; 4 responses; `last` only on the 4th; `bst_cmd_ready` high again after that handshake.
- 3-beat write at 0x40 with `bst_wdat_valid` toggled every other cycle → uops only on wdat cycles; exactly one response, `last`=1, err=0.
- Same write with `uop_rsp_err`=1 on beat 1 only → single response has err=1.
- 4-beat wrap read at 0x118 with the macro defined → addrs 0x118, 0x100, 0x108, 0x110. Without the macro → 0x118, 0x120, 0x128, 0x130.
- Read with `bst_rsp_ready` low for 3 cycles mid-burst → no beat lost or duplicated; data order preserved.
- `rst` pulsed after 2 of 8 read beats issued → FSM in IDLE next cycle; no further `uop_cmd_valid`; `splitter_active`=0.
